// File: rtl/rv_alu.sv
// RV32I execute-stage ALU: res is combinational (0 cycles), and res_q/zero_q/res_valid register it one cycle later.
// Backpressure: none. An operation is accepted on every cycle with in_valid=1.
module rv_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      alu_op1,
  input  logic [6:0]      alu_op2,
  input  logic [XLEN-1:0] s1,
  input  logic [XLEN-1:0] s2,
  input  logic            in_valid,
  output logic [XLEN-1:0] res,
  output logic [XLEN-1:0] res_q,
  output logic            res_valid,
  output logic            zero_q
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_e;

  typedef struct packed {
    logic [XLEN-1:0] dat;
    logic            zero;
  } wb_t;

  funct3_e op;
  logic    alt;
  logic    unused_funct7;

  assign op            = funct3_e'(alu_op1);
  assign alt           = alu_op2[5];
  assign unused_funct7 = ^{alu_op2[6], alu_op2[4:0]};

  // ---------------------------------------------------------------------------
  // Shared adder: ADD uses s1+s2. SUB and both compares use s1-s2.
  // ---------------------------------------------------------------------------
  logic            sub_en;
  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic            lt_u;
  logic            lt_s;

  assign sub_en = !((op == F3_ADD) && !alt);
  assign addend = s2 ^ {XLEN{sub_en}};
  assign sum    = {1'b0, s1} + {1'b0, addend} + {{XLEN{1'b0}}, sub_en};

  // No borrow out of s1-s2 means s1 >= s2 unsigned.
  assign lt_u = !sum[XLEN];
  assign lt_s = (s1[XLEN-1] != s2[XLEN-1]) ? s1[XLEN-1] : sum[XLEN-1];

  // ---------------------------------------------------------------------------
  // Single right-shift barrel. Left shifts are done by bit-reversing the input
  // and the output around the right shifter.
  // ---------------------------------------------------------------------------
  logic                     shift_left;
  logic                     fill;
  logic [XLEN-1:0]          sh_in;
  logic [XLEN-1:0]          sh_out;
  logic [XLEN-1:0]          sh_res;
  logic [SHW:0][XLEN-1:0]   stage;

  always_comb begin
    shift_left = (op == F3_SLL);
    fill       = (op == F3_SR) && alt && s1[XLEN-1];
    sh_in      = '0;
    for (int i = 0; i < XLEN; i++) begin
      sh_in[i] = shift_left ? s1[XLEN-1-i] : s1[i];
    end
  end

  assign stage[0] = sh_in;

  for (genvar k = 0; k < SHW; k++) begin : g_shift
    assign stage[k+1] = s2[k] ? {{(1 << k){fill}}, stage[k][XLEN-1:(1 << k)]}
                              : stage[k];
  end

  assign sh_out = stage[SHW];

  always_comb begin
    sh_res = '0;
    for (int i = 0; i < XLEN; i++) begin
      sh_res[i] = shift_left ? sh_out[XLEN-1-i] : sh_out[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Result select
  // ---------------------------------------------------------------------------
  always_comb begin
    res = '0;
    case (op)
      F3_ADD:  res = sum[XLEN-1:0];
      F3_SLL:  res = sh_res;
      F3_SLT:  res = {{(XLEN-1){1'b0}}, lt_s};
      F3_SLTU: res = {{(XLEN-1){1'b0}}, lt_u};
      F3_XOR:  res = s1 ^ s2;
      F3_SR:   res = sh_res;
      F3_OR:   res = s1 | s2;
      F3_AND:  res = s1 & s2;
      default: res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Writeback / forwarding register
  // ---------------------------------------------------------------------------
  wb_t wb_d;
  wb_t wb_q;

  assign wb_d.dat  = res;
  assign wb_d.zero = ~|res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q.dat  <= '0;
      wb_q.zero <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      res_valid <= in_valid;
      if (in_valid) begin
        wb_q <= wb_d;
      end
    end
  end

  assign res_q  = wb_q.dat;
  assign zero_q = wb_q.zero;

endmodule

// File: tb/tb_rv_alu.sv
// Self-checking bench for rv_alu: directed vectors plus randomized operands checked against a behavioural model.
module tb_rv_alu;

  logic        clk;
  logic        rst_n;
  logic [2:0]  alu_op1;
  logic [6:0]  alu_op2;
  logic [31:0] s1;
  logic [31:0] s2;
  logic        in_valid;
  logic [31:0] res;
  logic [31:0] res_q;
  logic        res_valid;
  logic        zero_q;

  int vectors;
  int miscompares;

  rv_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .s1        (s1),
    .s2        (s2),
    .in_valid  (in_valid),
    .res       (res),
    .res_q     (res_q),
    .res_valid (res_valid),
    .zero_q    (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Behavioural reference model, written directly from the RV32I operation definitions.
  function automatic logic [31:0] ref_alu(input logic [2:0] o1, input logic [6:0] o2,
                                          input logic [31:0] a, input logic [31:0] b);
    logic        alt;
    int unsigned sh;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] r;
    alt = o2[5];
    sh  = b % 32;
    sa  = a;
    sb  = b;
    r   = 32'd0;
    case (o1)
      3'd0: begin
        if (alt) r = a - b;
        else     r = a + b;
      end
      3'd1: r = a << sh;
      3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = sa >>> sh;
        else     r = a >> sh;
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [2:0] o1, input logic [6:0] o2,
                       input logic [31:0] a, input logic [31:0] b, input logic v);
    alu_op1  = o1;
    alu_op2  = o2;
    s1       = a;
    s2       = b;
    in_valid = v;
  endtask

  task automatic test_reset;
    drive(3'd0, 7'd0, 32'd5, 32'd7, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (res_q !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_res_q: got %h expected %h", res_q, 32'd0);
    end
    vectors++;
    if (zero_q !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_zero_q: got %b expected 1", zero_q);
    end
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_res_valid: got %b expected 0", res_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub;
    logic [2:0]  t_o1 [3] = '{3'd0, 3'd0, 3'd0};
    logic [6:0]  t_o2 [3] = '{7'h00, 7'h20, 7'h20};
    logic [31:0] t_a  [3] = '{32'd5, 32'd7, 32'd0};
    logic [31:0] t_b  [3] = '{32'd7, 32'd2, 32'd1};
    logic [31:0] t_e  [3] = '{32'd12, 32'd5, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      drive(t_o1[i], t_o2[i], t_a[i], t_b[i], 1'b0);
      #1;
      vectors++;
      if (res !== t_e[i]) begin
        miscompares++;
        $display("FAIL add_sub[%0d]: got %h expected %h", i, res, t_e[i]);
      end
    end
  endtask

  task automatic test_logic;
    logic [2:0]  t_o1 [3] = '{3'd4, 3'd6, 3'd7};
    logic [31:0] t_a  [3] = '{32'd3, 32'd2, 32'd3};
    logic [31:0] t_b  [3] = '{32'd1, 32'd6, 32'd2};
    logic [31:0] t_e  [3] = '{32'd2, 32'd6, 32'd2};
    for (int i = 0; i < 3; i++) begin
      drive(t_o1[i], 7'h00, t_a[i], t_b[i], 1'b0);
      #1;
      vectors++;
      if (res !== t_e[i]) begin
        miscompares++;
        $display("FAIL logic[%0d]: got %h expected %h", i, res, t_e[i]);
      end
    end
  endtask

  task automatic test_shifts;
    logic [2:0]  t_o1 [6] = '{3'd1, 3'd1, 3'd5, 3'd5, 3'd5, 3'd5};
    logic [6:0]  t_o2 [6] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h20};
    logic [31:0] t_a  [6] = '{32'h8000_0000, 32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b  [6] = '{32'd1, 32'h21, 32'd1, 32'd1, 32'd1, 32'd0};
    logic [31:0] t_e  [6] = '{32'd0, 32'd2, 32'd0, 32'h4000_0000, 32'hC000_0000, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      drive(t_o1[i], t_o2[i], t_a[i], t_b[i], 1'b0);
      #1;
      vectors++;
      if (res !== t_e[i]) begin
        miscompares++;
        $display("FAIL shift[%0d]: got %h expected %h", i, res, t_e[i]);
      end
    end
  endtask

  task automatic test_compares;
    logic [2:0]  t_o1 [4] = '{3'd2, 3'd2, 3'd3, 3'd3};
    logic [31:0] t_a  [4] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] t_b  [4] = '{32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] t_e  [4] = '{32'd1, 32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 4; i++) begin
      drive(t_o1[i], 7'h00, t_a[i], t_b[i], 1'b0);
      #1;
      vectors++;
      if (res !== t_e[i]) begin
        miscompares++;
        $display("FAIL compare[%0d]: got %h expected %h", i, res, t_e[i]);
      end
    end
  endtask

  task automatic test_x_check;
    logic [6:0]  ops2 [3] = '{7'h00, 7'h20, 7'h7F};
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    for (int o = 0; o < 8; o++) begin
      for (int m = 0; m < 3; m++) begin
        a = $urandom;
        b = $urandom;
        e = ref_alu(3'(o), ops2[m], a, b);
        drive(3'(o), ops2[m], a, b, 1'b0);
        #1;
        vectors++;
        if ($isunknown(res)) begin
          miscompares++;
          $display("FAIL xcheck op1=%0d op2=%h: got %h expected no X/Z", o, ops2[m], res);
        end
        vectors++;
        if (res !== e) begin
          miscompares++;
          $display("FAIL sweep op1=%0d op2=%h: got %h expected %h", o, ops2[m], res, e);
        end
      end
    end
  endtask

  task automatic test_register;
    // Capture pending when reset hits must be discarded.
    @(negedge clk);
    drive(3'd0, 7'h00, 32'd9, 32'd9, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (res_q !== 32'd0 || zero_q !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reg_async_reset: got res_q=%h zero_q=%b valid=%b expected 0/1/0", res_q, zero_q, res_valid);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (res_q !== 32'd0 || zero_q !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reg_held_in_reset: got res_q=%h zero_q=%b valid=%b expected 0/1/0", res_q, zero_q, res_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'd0, 7'h00, 32'd5, 32'd7, 1'b1);
    @(posedge clk);
    #1;
    vectors++;
    if (res_q !== 32'd12 || zero_q !== 1'b0 || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reg_first_capture: got res_q=%h zero_q=%b valid=%b expected 0000000c/0/1", res_q, zero_q, res_valid);
    end
    @(negedge clk);
    drive(3'd4, 7'h00, 32'd1, 32'd1, 1'b0);
    @(posedge clk);
    #1;
    vectors++;
    if (res_q !== 32'd12 || zero_q !== 1'b0 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reg_hold: got res_q=%h zero_q=%b valid=%b expected 0000000c/0/0", res_q, zero_q, res_valid);
    end
    @(negedge clk);
    drive(3'd0, 7'h20, 32'd3, 32'd3, 1'b1);
    @(posedge clk);
    #1;
    vectors++;
    if (res_q !== 32'd0 || zero_q !== 1'b1 || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reg_zero_flag: got res_q=%h zero_q=%b valid=%b expected 0/1/1", res_q, zero_q, res_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  o1;
    logic [6:0]  o2;
    logic [31:0] e;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      a  = $urandom;
      b  = (i % 3 == 0) ? a : $urandom;
      o1 = 3'($urandom_range(0, 7));
      o2 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      e  = ref_alu(o1, o2, a, b);
      drive(o1, o2, a, b, 1'b1);
      @(posedge clk);
      #1;
      vectors++;
      if (res_q !== e || zero_q !== (e == 32'd0) || res_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b[%0d] op1=%0d op2=%h: got res_q=%h zero_q=%b valid=%b expected %h/%b/1",
                 i, o1, o2, res_q, zero_q, res_valid, e, (e == 32'd0));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  o1;
    logic [6:0]  o2;
    logic [31:0] e;
    for (int i = 0; i < 300; i++) begin
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b[31:5] = '0;
      o1 = 3'($urandom_range(0, 7));
      o2 = 7'($urandom);
      e  = ref_alu(o1, o2, a, b);
      drive(o1, o2, a, b, 1'b0);
      #1;
      vectors++;
      if (res !== e) begin
        miscompares++;
        $display("FAIL random[%0d] op1=%0d op2=%h s1=%h s2=%h: got %h expected %h", i, o1, o2, a, b, res, e);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset;
    test_add_sub;
    test_logic;
    test_shifts;
    test_compares;
    test_x_check;
    test_register;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
